// File: rtl/debug_trace_tx.sv
// Commit-trace UART transmitter: buffers retired PCs in a FIFO and prints each one
// as 8 uppercase hex digits plus a newline over an 8N1 TX line.
module debug_trace_tx #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PC_WIDTH     = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_commit_valid,
    input  logic [PC_WIDTH-1:0] i_commit_pc,
    input  logic                i_trace_enable,
    input  logic                i_clear_overflow,
    output logic                o_txd,
    output logic                o_busy,
    output logic                o_overflow,
    output logic [15:0]         o_drop_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [PC_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic [PC_WIDTH-1:0] r_line;
    logic [7:0]          r_tx_byte;
    logic [3:0]          r_byte_idx;
    logic [2:0]          r_bit_idx;
    logic [TW-1:0]       r_timer;
    logic                r_txd;
    logic                r_overflow;
    logic [15:0]         r_drop_count;

    logic       w_empty;
    logic       w_full;
    logic       w_push_req;
    logic       w_push;
    logic       w_drop;
    logic       w_pop;
    logic       w_tick;
    logic       w_txd_next;
    logic [7:0] w_ascii;

    // Byte idx 0..7 selects a hex digit (MS nibble first); idx 8 is the newline.
    function automatic logic [7:0] hex_ascii(input logic [31:0] line, input logic [3:0] idx);
        logic [3:0] nib;
        if (idx >= 4'd8) begin
            return 8'h0A;
        end
        nib = 4'(line >> (5'd28 - {idx[2:0], 2'b00}));
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push_req = i_commit_valid & i_trace_enable;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;
    assign w_tick     = (r_timer == '0);
    assign w_ascii    = hex_ascii(r_line, r_byte_idx);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // txd is registered from the next-state decode so the pin never glitches.
    always_comb begin
        w_state_next = r_state;
        w_txd_next   = r_txd;
        w_pop        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = StStart;
                    w_txd_next   = 1'b0;
                end
            end
            StStart: begin
                if (w_tick) begin
                    w_state_next = StData;
                    w_txd_next   = w_ascii[0];
                end
            end
            StData: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = StStop;
                        w_txd_next   = 1'b1;
                    end else begin
                        w_txd_next = r_tx_byte[r_bit_idx + 3'd1];
                    end
                end
            end
            StStop: begin
                if (w_tick) begin
                    if (r_byte_idx == 4'd8) begin
                        w_state_next = StIdle;
                    end else begin
                        w_state_next = StStart;
                        w_txd_next   = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
                w_txd_next   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_txd        <= 1'b1;
            r_timer      <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_line       <= '0;
            r_tx_byte    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_txd <= w_txd_next;

            // Reload on every bit boundary; the bit timer free-runs only while framing.
            if ((r_state != w_state_next) || (r_state == StData && w_tick)) begin
                r_timer <= TW'(CLKS_PER_BIT - 1);
            end else if (!w_tick) begin
                r_timer <= r_timer - TW'(1);
            end

            if (w_pop) begin
                r_line     <= r_mem[r_rd_ptr[AW-1:0]];
                r_byte_idx <= '0;
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            if (r_state == StStart && w_tick) begin
                r_tx_byte <= w_ascii;
                r_bit_idx <= '0;
            end
            if (r_state == StData && w_tick) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (r_state == StStop && w_tick && r_byte_idx != 4'd8) begin
                r_byte_idx <= r_byte_idx + 4'd1;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            // A drop in the same cycle as a clear still registers as one drop.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (i_clear_overflow) begin
                    r_drop_count <= 16'd1;
                end else if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end else if (i_clear_overflow) begin
                r_overflow   <= 1'b0;
                r_drop_count <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_commit_pc;
        end
    end

    assign o_txd        = r_txd;
    assign o_busy       = (r_state != StIdle) | ~w_empty;
    assign o_overflow   = r_overflow;
    assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_debug_trace_tx.sv
// Bench for debug_trace_tx: a queue-based reference model predicts txd, busy, overflow and
// dropCount every cycle from the line-timing arithmetic.
module tb_debug_trace_tx;

    localparam int CPB      = 4;
    localparam int DEPTH    = 4;
    localparam int LINE_CYC = 90 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cv  = 1'b0;
    logic        te  = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] pc  = '0;
    logic        txd;
    logic        busy;
    logic        ovf;
    logic [15:0] dc;

    int total = 0;
    int bad   = 0;

    debug_trace_tx #(
        .FIFO_DEPTH  (DEPTH),
        .CLKS_PER_BIT(CPB),
        .PC_WIDTH    (32)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_commit_valid  (cv),
        .i_commit_pc     (pc),
        .i_trace_enable  (te),
        .i_clear_overflow(clr),
        .o_txd           (txd),
        .o_busy          (busy),
        .o_overflow      (ovf),
        .o_drop_count    (dc)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0] mq[$];
    int          rem    = 0;
    logic [31:0] cur_pc = '0;
    logic        m_ovf  = 1'b0;
    logic [15:0] m_dc   = '0;
    logic        m_drop;

    function automatic logic [7:0] asc(input logic [31:0] p, input int k);
        int d;
        if (k == 8) return 8'h0A;
        d = int'((p >> (28 - 4 * k)) & 32'hF);
        return (d < 10) ? 8'(48 + d) : 8'(55 + d);
    endfunction

    function automatic logic exp_txd();
        int e, b, bi;
        logic [7:0] ch;
        if (rem == 0) return 1'b1;
        e  = LINE_CYC - rem;
        b  = e / (10 * CPB);
        bi = (e % (10 * CPB)) / CPB;
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        ch = asc(cur_pc, b);
        return ch[bi-1];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            rem   = 0;
            m_ovf = 1'b0;
            m_dc  = '0;
        end else begin
            if (rem == 0 && mq.size() > 0) begin
                cur_pc = mq.pop_front();
                rem    = LINE_CYC;
            end else if (rem > 0) begin
                rem--;
            end
            m_drop = 1'b0;
            if (cv && te) begin
                if (mq.size() < DEPTH) mq.push_back(pc);
                else m_drop = 1'b1;
            end
            if (m_drop) begin
                m_ovf = 1'b1;
                m_dc  = clr ? 16'd1 : ((m_dc == 16'hFFFF) ? m_dc : m_dc + 16'd1);
            end else if (clr) begin
                m_ovf = 1'b0;
                m_dc  = '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("txd", {31'd0, txd}, {31'd0, exp_txd()});
        chk("busy", {31'd0, busy}, {31'd0, (rem > 0 || mq.size() > 0)});
        chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
        chk("dropCount", {16'd0, dc}, {16'd0, m_dc});
    end

    task automatic commit(input logic [31:0] p);
        cv = 1'b1;
        pc = p;
        @(negedge clk);
        cv = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dc", {16'd0, dc}, 32'd0);

        // T1: single line, first-frame latency.
        te = 1'b1;
        commit(32'h80000004);
        chk("t1_lat_high", {31'd0, txd}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t1_start_low", {31'd0, txd}, 32'd0);
        wait_idle(2000);

        // T2: uppercase hex digits.
        commit(32'hDEADBEEF);
        wait_idle(2000);

        // T3/T4: overflow, clear, and clear colliding with a drop.
        cv = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pc = $urandom;
            @(negedge clk);
        end
        cv = 1'b0;
        chk("t3_overflow", {31'd0, ovf}, 32'd1);
        chk("t3_dropcount", {16'd0, dc}, 32'd2);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t3_clr_ovf", {31'd0, ovf}, 32'd0);
        chk("t3_clr_dc", {16'd0, dc}, 32'd0);
        cv  = 1'b1;
        clr = 1'b1;
        pc  = $urandom;
        @(negedge clk);
        cv  = 1'b0;
        clr = 1'b0;
        chk("t4_overflow", {31'd0, ovf}, 32'd1);
        chk("t4_dropcount", {16'd0, dc}, 32'd1);
        wait_idle(5000);

        // T5: capture disabled, then disabled mid-line with a second entry buffered.
        te = 1'b0;
        for (int i = 0; i < 3; i++) commit($urandom);
        chk("t5_idle_txd", {31'd0, txd}, 32'd1);
        chk("t5_idle_busy", {31'd0, busy}, 32'd0);
        te = 1'b1;
        commit($urandom);
        commit($urandom);
        repeat (50) @(negedge clk);
        te = 1'b0;
        wait_idle(2000);

        // Randomized traffic with occasional clears and enable toggles.
        for (int i = 0; i < 600; i++) begin
            cv  = ($urandom_range(0, 9) == 0);
            pc  = $urandom;
            te  = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        cv  = 1'b0;
        clr = 1'b0;
        wait_idle(20000);

        // T6: asynchronous reset in the middle of a data bit.
        te = 1'b1;
        commit($urandom);
        repeat (2 + 3 * CPB) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_txd", {31'd0, txd}, 32'd1);
        chk("t6_async_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        commit(32'h0000A5F0);
        wait_idle(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
